ccgc_decode_n: RTL and testbench

Parametrised complementary-Gray-code (CCGC) phase-order decoder. It takes one pixel per cycle of N Gray-code pattern bits plus the complementary pattern bit. It produces the fringe orders K1 (N-1 bit Gray code), K2 (N bit Gray code, half-period shifted) and the complementary bit K3, tagged with pixel coordinates. It sits between the pattern binarisation stage and the phase-unwrapping stage. It generalises the fixed 4-pattern decoder with configurable pattern count, a runtime correction mode, valid/ready backpressure and coordinate tracking.

---
 rtl/ccgc_pkg.sv | 43 ++++
 rtl/ccgc_gray2bin.sv | 13 +
 rtl/ccgc_decode_n.sv | 191 +++++++++++++++++++
 tb/tb_ccgc_decode_n.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ccgc_pkg.sv
// Shared definitions for the CCGC phase-order decoder: correction-mode
// encodings and the Gray-to-binary helper used by the converter.
package ccgc_pkg;

    // MSB correction modes selected by corr_mode.
    localparam logic [1:0] CORR_NEVER  = 2'd0;
    localparam logic [1:0] CORR_ALWAYS = 2'd1;
    localparam logic [1:0] CORR_EVEN   = 2'd2;
    localparam logic [1:0] CORR_ODD    = 2'd3;

    // Widest Gray word the helper converts (N_BITS is at most 8).
    localparam int GRAY_MAX_W = 8;

    // Gray-to-binary on the low w bits of g: b[i] = XOR of g[w-1:i].
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g,
                                                       input int                    w);
        logic [GRAY_MAX_W-1:0] b;
        logic                  acc;
        b   = '0;
        acc = 1'b0;
        for (int i = GRAY_MAX_W - 1; i >= 0; i--) begin
            if (i < w) begin
                acc  = acc ^ g[i];
                b[i] = acc;
            end
        end
        return b;
    endfunction

    // Whether the MSB is corrected for this mode and frame parity (0 = even).
    function automatic logic corr_enable(input logic [1:0] mode, input logic parity);
        logic corr;
        corr = 1'b0;
        unique case (mode)
            CORR_NEVER:  corr = 1'b0;
            CORR_ALWAYS: corr = 1'b1;
            CORR_EVEN:   corr = ~parity;
            CORR_ODD:    corr = parity;
        endcase
        return corr;
    endfunction

endpackage

// File: rtl/ccgc_gray2bin.sv
// Combinational Gray-to-binary converter of width W.
module ccgc_gray2bin
    import ccgc_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [W-1:0] gray_i,
    output logic [W-1:0] bin_o
);

    assign bin_o = W'(gray2bin(GRAY_MAX_W'(gray_i), W));

endmodule

// File: rtl/ccgc_decode_n.sv
// CCGC phase-order decoder: one pixel per cycle of N Gray bits plus the
// complementary bit in, fringe orders K1/K2/K3 with pixel coordinates out.
// Three-stage pipeline (correct, convert, shift) under one advance enable.
module ccgc_decode_n
    import ccgc_pkg::*;
#(
    parameter int N_BITS = 4,
    parameter int X_W    = 11,
    parameter int Y_W    = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_valid,
    input  logic              line_valid,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N_BITS-1:0] gray_in,
    input  logic              gray_cmp,
    input  logic [1:0]        corr_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N_BITS-2:0] k1_out,
    output logic [N_BITS-1:0] k2_out,
    output logic              k3_out,
    output logic [X_W-1:0]    x_out,
    output logic [Y_W-1:0]    y_out,
    output logic              frame_parity
);

    localparam int MSB = N_BITS - 1;

    // Front end: edge detectors, frame parity and coordinate counters.
    logic           fv_q;
    logic           lv_q;
    logic           parity_q;
    logic [X_W-1:0] x_q;
    logic [Y_W-1:0] y_q;

    // S1: corrected Gray word, K3 and coordinates.
    logic              s1_valid_q;
    logic [N_BITS-1:0] s1_gray_q;
    logic              s1_k3_q;
    logic [X_W-1:0]    s1_x_q;
    logic [Y_W-1:0]    s1_y_q;

    // S2: binary orders.
    logic              s2_valid_q;
    logic [N_BITS-2:0] s2_k1_q;
    logic [N_BITS-1:0] s2_iv2_q;
    logic              s2_k3_q;
    logic [X_W-1:0]    s2_x_q;
    logic [Y_W-1:0]    s2_y_q;

    // S3: output register.
    logic              out_valid_q;
    logic [N_BITS-2:0] k1_q;
    logic [N_BITS-1:0] k2_q;
    logic              k3_q;
    logic [X_W-1:0]    x_out_q;
    logic [Y_W-1:0]    y_out_q;

    logic              en;
    logic              accept;
    logic              frame_start;
    logic              line_fall;
    logic              k3_d;
    logic [N_BITS-1:0] gray_d;
    logic [N_BITS-2:0] k1_d;
    logic [N_BITS-1:0] iv2_d;
    logic [N_BITS:0]   k2_wide;
    logic [N_BITS-1:0] k2_d;

    // K1 comes from the top N-1 Gray bits, IV2 from all N.
    ccgc_gray2bin #(.W(N_BITS - 1)) u_k1_conv (
        .gray_i (s1_gray_q[MSB:1]),
        .bin_o  (k1_d)
    );

    ccgc_gray2bin #(.W(N_BITS)) u_iv2_conv (
        .gray_i (s1_gray_q),
        .bin_o  (iv2_d)
    );

    // Handshake, edge detection, S1 MSB correction and the S3 half-period shift.
    always_comb begin
        // NOTE: every output of this block is assigned before any condition,
        // so no path leaves a value unassigned and no latch is inferred.
        en          = ~out_valid_q | out_ready;
        accept      = in_valid & en & line_valid;
        frame_start = frame_valid & ~fv_q;
        line_fall   = lv_q & ~line_valid;
        k3_d        = gray_in[MSB] ^ gray_cmp;
        gray_d      = gray_in;
        if (corr_enable(corr_mode, parity_q)) begin
            gray_d[MSB] = gray_in[MSB] ^ k3_d;
        end
        // N+1 bits so that IV2 = all-ones does not wrap before the shift.
        k2_wide = {1'b0, s2_iv2_q} + {{N_BITS{1'b0}}, 1'b1};
        k2_d    = N_BITS'(k2_wide >> 1);
    end

    // Frame/line edge detection, frame parity and pixel coordinate counters.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            // Held high through reset so a frame_valid already high when reset
            // releases is a frame in progress, not a new frame start.
            fv_q     <= 1'b1;
            lv_q     <= 1'b0;
            parity_q <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
        end else begin
            fv_q <= frame_valid;
            lv_q <= line_valid;
            if (frame_start) begin
                parity_q <= ~parity_q;
            end
            if (!line_valid) begin
                x_q <= '0;
            end else if (accept && (x_q != '1)) begin
                x_q <= x_q + 1'b1;
            end
            if (frame_start) begin
                y_q <= '0;
            end else if (line_fall && (y_q != '1)) begin
                y_q <= y_q + 1'b1;
            end
        end
    end

    // Three-stage pipeline; all stages advance together when en is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the data registers are reset along with the valids so the
            // outputs read 0 after reset and never carry X downstream.
            s1_valid_q  <= 1'b0;
            s1_gray_q   <= '0;
            s1_k3_q     <= 1'b0;
            s1_x_q      <= '0;
            s1_y_q      <= '0;
            s2_valid_q  <= 1'b0;
            s2_k1_q     <= '0;
            s2_iv2_q    <= '0;
            s2_k3_q     <= 1'b0;
            s2_x_q      <= '0;
            s2_y_q      <= '0;
            out_valid_q <= 1'b0;
            k1_q        <= '0;
            k2_q        <= '0;
            k3_q        <= 1'b0;
            x_out_q     <= '0;
            y_out_q     <= '0;
        end else if (en) begin
            s1_valid_q <= accept;
            if (accept) begin
                s1_gray_q <= gray_d;
                s1_k3_q   <= k3_d;
                s1_x_q    <= x_q;
                s1_y_q    <= y_q;
            end
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_k1_q  <= k1_d;
                s2_iv2_q <= iv2_d;
                s2_k3_q  <= s1_k3_q;
                s2_x_q   <= s1_x_q;
                s2_y_q   <= s1_y_q;
            end
            out_valid_q <= s2_valid_q;
            if (s2_valid_q) begin
                k1_q    <= s2_k1_q;
                k2_q    <= k2_d;
                k3_q    <= s2_k3_q;
                x_out_q <= s2_x_q;
                y_out_q <= s2_y_q;
            end
        end
    end

    assign in_ready     = en;
    assign out_valid    = out_valid_q;
    assign k1_out       = k1_q;
    assign k2_out       = k2_q;
    assign k3_out       = k3_q;
    assign x_out        = x_out_q;
    assign y_out        = y_out_q;
    assign frame_parity = parity_q;

endmodule

// File: tb/tb_ccgc_decode_n.sv
// Scoreboard bench for ccgc_decode_n: a 4-bit and a 2-bit instance share the
// stimulus; expected orders come from a bench-side decode model or constants.
`timescale 1ns/1ps
module tb_ccgc_decode_n;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_valid;
    logic        line_valid;
    logic        in_valid;
    logic        in_ready;
    logic        in_ready2;
    logic [3:0]  gray_in;
    logic        gray_cmp;
    logic [1:0]  corr_mode;
    logic        out_ready;
    logic        out_valid;
    logic [2:0]  k1_out;
    logic [3:0]  k2_out;
    logic        k3_out;
    logic [10:0] x_out;
    logic [10:0] y_out;
    logic        frame_parity;
    logic        out_valid2;
    logic [0:0]  k1_out2;
    logic [1:0]  k2_out2;
    logic        k3_out2;
    logic [10:0] x_out2;
    logic [10:0] y_out2;
    logic        frame_parity2;

    typedef struct {
        int k1;
        int k2;
        int k3;
        int x;
        int y;
        bit lat;
        int cyc;
    } exp_t;

    exp_t sb1[$];
    exp_t sb2[$];
    exp_t pend1;
    exp_t pend2;

    int n_checks    = 0;
    int n_errors    = 0;
    int cyc         = 0;
    int stall_left  = 0;
    int ready_low   = 0;
    int max2        = 0;
    int tb_x        = 0;
    int tb_y        = 0;
    bit tb_par      = 1'b0;
    bit accepted    = 1'b0;

    always #5 clk = ~clk;

    ccgc_decode_n #(.N_BITS(4), .X_W(11), .Y_W(11)) dut (
        .clk          (clk),
        .rst          (rst),
        .frame_valid  (frame_valid),
        .line_valid   (line_valid),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .gray_in      (gray_in),
        .gray_cmp     (gray_cmp),
        .corr_mode    (corr_mode),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .k1_out       (k1_out),
        .k2_out       (k2_out),
        .k3_out       (k3_out),
        .x_out        (x_out),
        .y_out        (y_out),
        .frame_parity (frame_parity)
    );

    ccgc_decode_n #(.N_BITS(2), .X_W(11), .Y_W(11)) dut2 (
        .clk          (clk),
        .rst          (rst),
        .frame_valid  (frame_valid),
        .line_valid   (line_valid),
        .in_valid     (in_valid),
        .in_ready     (in_ready2),
        .gray_in      (gray_in[1:0]),
        .gray_cmp     (gray_cmp),
        .corr_mode    (corr_mode),
        .out_valid    (out_valid2),
        .out_ready    (out_ready),
        .k1_out       (k1_out2),
        .k2_out       (k2_out2),
        .k3_out       (k3_out2),
        .x_out        (x_out2),
        .y_out        (y_out2),
        .frame_parity (frame_parity2)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Reference decode: optional MSB correction, Gray-to-binary by running XOR.
    function automatic exp_t model(input logic [7:0] g_in, input bit cmp, input int n,
                                   input logic [1:0] mode, input bit par);
        exp_t       e;
        logic [7:0] g;
        int         iv2;
        bit         acc;
        bit         corr;
        g    = g_in;
        e.k3 = int'(g[n-1] ^ cmp);
        corr = (mode == 2'd1) || (mode == 2'd2 && !par) || (mode == 2'd3 && par);
        if (corr) g[n-1] = g[n-1] ^ e.k3[0];
        iv2 = 0;
        acc = 1'b0;
        for (int i = n - 1; i >= 0; i--) begin
            acc = acc ^ g[i];
            iv2 = iv2 | (int'(acc) << i);
        end
        e.k1  = iv2 >> 1;
        e.k2  = (iv2 + 1) >> 1;
        e.x   = tb_x;
        e.y   = tb_y;
        e.lat = 1'b0;
        e.cyc = 0;
        return e;
    endfunction

    // One clock: called just after a falling edge with inputs already set.
    task automatic tick();
        exp_t e;
        if (stall_left > 0) begin
            out_ready  = 1'b0;
            stall_left = stall_left - 1;
        end else begin
            out_ready = 1'b1;
        end
        #1;
        if (!in_ready) ready_low++;
        check("in_ready", in_ready, !(out_valid && !out_ready));
        if (out_valid && out_ready) begin
            if (sb1.size() == 0) begin
                check("spurious_out", out_valid, 0);
            end else begin
                e = sb1.pop_front();
                check("k1", k1_out, e.k1);
                check("k2", k2_out, e.k2);
                check("k3", k3_out, e.k3);
                check("x", x_out, e.x);
                check("y", y_out, e.y);
                if (e.lat) check("latency", cyc - e.cyc, 3);
            end
        end
        if (out_valid2 && out_ready) begin
            if (sb2.size() == 0) begin
                check("spurious_out2", out_valid2, 0);
            end else begin
                e = sb2.pop_front();
                check("n2_k1", k1_out2, e.k1);
                check("n2_k2", k2_out2, e.k2);
                check("n2_k3", k3_out2, e.k3);
                check("n2_x", x_out2, e.x);
                if (int'(k2_out2) > max2) max2 = int'(k2_out2);
            end
        end
        accepted = in_valid && in_ready && line_valid;
        if (accepted) begin
            pend1.cyc = cyc;
            sb1.push_back(pend1);
        end
        if (in_valid && in_ready2 && line_valid) sb2.push_back(pend2);
        @(negedge clk);
        cyc++;
    endtask

    task automatic present(input logic [3:0] g, input bit cmp);
        gray_in  = g;
        gray_cmp = cmp;
        in_valid = 1'b1;
        accepted = 1'b0;
        for (int t = 0; t < 20; t++) begin
            tick();
            if (accepted) break;
        end
        if (!accepted) check("accept_timeout", in_ready, 1);
        in_valid = 1'b0;
        tb_x++;
    endtask

    task automatic send(input logic [3:0] g, input bit cmp);
        pend1 = model({4'b0, g}, cmp, 4, corr_mode, tb_par);
        pend2 = model({4'b0, g}, cmp, 2, corr_mode, tb_par);
        present(g, cmp);
    endtask

    task automatic send_exp(input logic [3:0] g, input bit cmp, input int k1, input int k2,
                            input int k3, input bit lat);
        pend1     = model({4'b0, g}, cmp, 4, corr_mode, tb_par);
        pend1.k1  = k1;
        pend1.k2  = k2;
        pend1.k3  = k3;
        pend1.lat = lat;
        pend2     = model({4'b0, g}, cmp, 2, corr_mode, tb_par);
        present(g, cmp);
    endtask

    task automatic drain();
        in_valid = 1'b0;
        for (int t = 0; t < 50 && (sb1.size() > 0 || sb2.size() > 0); t++) tick();
        check("drain_sb1", sb1.size(), 0);
        check("drain_sb2", sb2.size(), 0);
    endtask

    task automatic new_frame();
        frame_valid = 1'b0;
        tick();
        frame_valid = 1'b1;
        tick();
        tb_par = ~tb_par;
        tb_y   = 0;
        check("frame_parity", frame_parity, tb_par);
        check("frame_parity2", frame_parity2, tb_par);
    endtask

    task automatic start_line();
        line_valid = 1'b1;
    endtask

    task automatic end_line();
        line_valid = 1'b0;
        in_valid   = 1'b0;
        tick();
        tb_y++;
        tb_x = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        frame_valid = 1'b0;
        line_valid  = 1'b0;
        in_valid    = 1'b0;
        gray_in     = '0;
        gray_cmp    = 1'b0;
        corr_mode   = 2'd0;
        out_ready   = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_valid2", out_valid2, 0);
        check("rst_parity", frame_parity, 0);
        check("rst_k2", k2_out, 0);
        check("rst_x", x_out, 0);
        check("rst_y", y_out, 0);
        rst = 1'b0;

        // Frame 1 (odd): basic decode, correction always, parity modes.
        new_frame();
        start_line();
        corr_mode = 2'd0; send_exp(4'b0110, 1'b1, 2, 2, 1, 1'b1); drain();
        corr_mode = 2'd1; send_exp(4'b0110, 1'b1, 5, 6, 1, 1'b1); drain();
        corr_mode = 2'd2; send_exp(4'b0110, 1'b1, 2, 2, 1, 1'b0);
        corr_mode = 2'd3; send_exp(4'b0110, 1'b1, 5, 6, 1, 1'b0);
        drain();
        end_line();
        new_frame();  // even
        start_line();
        corr_mode = 2'd2; send_exp(4'b0110, 1'b1, 5, 6, 1, 1'b0);
        corr_mode = 2'd3; send_exp(4'b0110, 1'b1, 2, 2, 1, 1'b0);
        drain();

        // Exhaustive sweep, mode 1, cmp = MSB; then random modes and inputs.
        corr_mode = 2'd1;
        for (int g = 0; g < 16; g++) begin
            logic [3:0] gv;
            gv = 4'(g);
            send(gv, gv[3]);
        end
        for (int i = 0; i < 16; i++) begin
            corr_mode = 2'($urandom_range(0, 3));
            send(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        end
        drain();
        end_line();

        // Backpressure: 8 pixels with a 5-cycle downstream stall mid-stream.
        start_line();
        corr_mode = 2'd0;
        for (int i = 0; i < 8; i++) begin
            if (i == 4) begin
                stall_left = 5;
                ready_low  = 0;
            end
            send(4'(i), 1'(i));
        end
        check("stall_ready_low", ready_low, 5);
        drain();
        end_line();

        // Three lines of four pixels in a fresh frame.
        new_frame();
        for (int l = 0; l < 3; l++) begin
            start_line();
            for (int p = 0; p < 4; p++) send(4'($urandom_range(0, 15)), 1'b0);
            end_line();
        end
        drain();

        // Frame start with a pixel in flight keeps its y and parity.
        start_line();
        corr_mode = 2'd2;
        send(4'b0110, 1'b1);
        new_frame();
        drain();
        end_line();

        // Pixels while line_valid is low are dropped and not counted.
        in_valid = 1'b1;
        gray_in  = 4'hF;
        repeat (3) tick();
        in_valid = 1'b0;
        start_line();
        send(4'b0011, 1'b0);
        drain();

        // Reset mid-line with pixels in flight and frame_valid still high.
        send(4'b0101, 1'b0);
        send(4'b1001, 1'b1);
        rst      = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_x", x_out, 0);
        check("midrst_y", y_out, 0);
        check("midrst_parity", frame_parity, 0);
        sb1.delete();
        sb2.delete();
        tb_par = 1'b0;
        tb_x   = 0;
        tb_y   = 0;
        rst    = 1'b0;
        tick();
        tick();
        check("no_spurious_frame", frame_parity, 0);
        corr_mode = 2'd2;
        send(4'b0110, 1'b1);
        send(4'b1100, 1'b0);
        drain();
        end_line();

        check("n2_max_k2", max2, 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
